// File: rtl/onehot_reg_bank.sv
// Register bank written through a one-hot enable; async-cleared flops, two combinational read ports.
// Latency: 1-cycle write-to-read, or 0 with REG_BANK_BYPASS_EN (write-first forwarding of a clean one-hot write).
// Backpressure: none; multi-hot or unknown enables drop the write and raise sticky wr_err.
module onehot_reg_bank #(
    parameter int BUS_WIDTH = 8,
    parameter int NB_SEL    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2**NB_SEL-1:0]    wr_en,
    input  logic [BUS_WIDTH-1:0]    wr_data,
    input  logic [NB_SEL-1:0]       rd_sel_a,
    input  logic [NB_SEL-1:0]       rd_sel_b,
    output logic [BUS_WIDTH-1:0]    rd_data_a,
    output logic [BUS_WIDTH-1:0]    rd_data_b,
    output logic                    rd_valid_a,
    output logic                    rd_valid_b,
    output logic [2**NB_SEL-1:0]    written,
    output logic                    wr_err,
    input  logic                    wr_err_clr
);
    localparam int NB_REGS = 2**NB_SEL;

    logic [BUS_WIDTH-1:0] regs [NB_REGS];
    logic [NB_REGS-1:0]   written_q;
    logic                 wr_err_q;
    logic                 en_zero;
    logic                 en_onehot;
    logic                 en_multi;

    // Case equality makes any X/Z bit on wr_en fall into the multi-hot class.
    always_comb begin
        en_zero   = (wr_en === '0);
        en_onehot = !en_zero && ((wr_en & (wr_en - NB_REGS'(1))) === '0);
        en_multi  = !en_zero && !en_onehot;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NB_REGS; i++) begin
                regs[i] <= '0;
            end
            written_q <= '0;
        end else if (en_onehot) begin
            for (int i = 0; i < NB_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i]      <= wr_data;
                    written_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_q <= 1'b0;
        end else if (en_multi) begin
            wr_err_q <= 1'b1;
        end else if (wr_err_clr) begin
            wr_err_q <= 1'b0;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    always_comb begin
        rd_data_a  = regs[rd_sel_a];
        rd_valid_a = written_q[rd_sel_a];
        rd_data_b  = regs[rd_sel_b];
        rd_valid_b = written_q[rd_sel_b];
        if (en_onehot && wr_en[rd_sel_a]) begin
            rd_data_a  = wr_data;
            rd_valid_a = 1'b1;
        end
        if (en_onehot && wr_en[rd_sel_b]) begin
            rd_data_b  = wr_data;
            rd_valid_b = 1'b1;
        end
    end
`else
    always_comb begin
        rd_data_a  = regs[rd_sel_a];
        rd_valid_a = written_q[rd_sel_a];
        rd_data_b  = regs[rd_sel_b];
        rd_valid_b = written_q[rd_sel_b];
    end
`endif

    assign written = written_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_onehot_reg_bank.sv
// Randomised and directed checks of onehot_reg_bank against an array-based reference model.
module tb_onehot_reg_bank;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] wr_en = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] rd_sel_a = '0;
    logic [2:0] rd_sel_b = '0;
    logic       wr_err_clr = 1'b0;
    logic [7:0] rd_data_a, rd_data_b, written;
    logic       rd_valid_a, rd_valid_b, wr_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_mem [8] = '{default: 8'h00};
    logic [7:0] m_written = '0;
    logic       m_err = 1'b0;

    onehot_reg_bank #(.BUS_WIDTH(8), .NB_SEL(3)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .written(written), .wr_err(wr_err), .wr_err_clr(wr_err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
            m_written = '0;
            m_err = 1'b0;
        end else begin
            if ($countones(wr_en) == 1) begin
                m_mem[$clog2(wr_en)] = wr_data;
                m_written[$clog2(wr_en)] = 1'b1;
            end
            if ($countones(wr_en) > 1) m_err = 1'b1;
            else if (wr_err_clr) m_err = 1'b0;
        end
    end

    function automatic logic [8:0] exp_read(input logic [2:0] sel);
        logic [8:0] r;
        r = {m_written[sel], m_mem[sel]};
`ifdef REG_BANK_BYPASS_EN
        if ($countones(wr_en) == 1 && wr_en[sel]) r = {1'b1, wr_data};
`endif
        return r;
    endfunction

    // Continuous comparison away from the active edge
    always @(negedge clk) begin
        logic [8:0] ea, eb;
        ea = exp_read(rd_sel_a);
        eb = exp_read(rd_sel_b);
        chk("rd_data_a", rd_data_a, ea[7:0]);
        chk("rd_valid_a", {7'd0, rd_valid_a}, {7'd0, ea[8]});
        chk("rd_data_b", rd_data_b, eb[7:0]);
        chk("rd_valid_b", {7'd0, rd_valid_b}, {7'd0, eb[8]});
        chk("written", written, m_written);
        chk("wr_err", {7'd0, wr_err}, {7'd0, m_err});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset sweep
        #1;
        for (int i = 0; i < 8; i++) begin
            rd_sel_a = 3'(i);
            #1;
            chk("rst_rd_data_a", rd_data_a, 8'h00);
            chk("rst_rd_valid_a", {7'd0, rd_valid_a}, 8'h00);
        end
        chk("rst_written", written, 8'h00);
        chk("rst_wr_err", {7'd0, wr_err}, 8'h00);
        step();
        reset_n = 1'b1;
        step();

        // Single write to reg3
        wr_en = 8'b0000_1000; wr_data = 8'hA5; rd_sel_a = 3'd3;
        #2;
`ifdef REG_BANK_BYPASS_EN
        chk("pre_edge_a", rd_data_a, 8'hA5);
`else
        chk("pre_edge_a", rd_data_a, 8'h00);
`endif
        step();
        wr_en = '0;
        #1;
        chk("single_data", rd_data_a, 8'hA5);
        chk("single_valid", {7'd0, rd_valid_a}, 8'h01);
        chk("single_written", written, 8'h08);

        // Multi-hot rejection and error set/clear priority
        wr_en = 8'b0011_0000; wr_data = 8'hFF; rd_sel_a = 3'd4; rd_sel_b = 3'd5;
        step();
        wr_en = 8'b1000_0001; wr_err_clr = 1'b1;
        #1;
        chk("multi_err", {7'd0, wr_err}, 8'h01);
        chk("multi_reg4", rd_data_a, 8'h00);
        chk("multi_reg5", rd_data_b, 8'h00);
        chk("multi_written", written, 8'h08);
        step();
        wr_en = '0;
        #1;
        chk("set_wins", {7'd0, wr_err}, 8'h01);
        step();
        wr_err_clr = 1'b0;
        #1;
        chk("err_cleared", {7'd0, wr_err}, 8'h00);

        // Overwrite with dual read
        wr_en = 8'b0000_0100; wr_data = 8'h11; rd_sel_a = 3'd2; rd_sel_b = 3'd2;
        step();
        wr_data = 8'h22;
        step();
        wr_en = '0;
        #1;
        chk("dual_a", rd_data_a, 8'h22);
        chk("dual_b", rd_data_b, 8'h22);
        chk("dual_written2", {7'd0, written[2]}, 8'h01);

        // Same-cycle forwarding
        wr_en = 8'b0100_0000; wr_data = 8'h5C; rd_sel_b = 3'd6;
        #2;
`ifdef REG_BANK_BYPASS_EN
        chk("bypass_data", rd_data_b, 8'h5C);
        chk("bypass_valid", {7'd0, rd_valid_b}, 8'h01);
`else
        chk("bypass_data", rd_data_b, 8'h00);
        chk("bypass_valid", {7'd0, rd_valid_b}, 8'h00);
`endif
        step();

        // Async reset between edges
        wr_en = 8'b1000_0000; wr_data = 8'h77;
        step();
        wr_en = '0; rd_sel_a = 3'd7;
        #1;
        chk("pre_rst_reg7", rd_data_a, 8'h77);
        reset_n = 1'b0;
        #1;
        chk("async_reg7", rd_data_a, 8'h00);
        chk("async_written", written, 8'h00);
        reset_n = 1'b1;
        wr_en = 8'b1000_0000; wr_data = 8'h99;
        step();
        wr_en = '0;
        #1;
        chk("post_rst_reg7", rd_data_a, 8'h99);
        chk("post_rst_written", written, 8'h80);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            step();
            case ($urandom_range(3))
                0: wr_en = '0;
                1, 2: wr_en = 8'(1 << $urandom_range(7));
                default: wr_en = 8'($urandom);
            endcase
            wr_data    = 8'($urandom);
            rd_sel_a   = 3'($urandom_range(7));
            rd_sel_b   = 3'($urandom_range(7));
            wr_err_clr = ($urandom_range(7) == 0);
            if ($urandom_range(99) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        step();
        wr_en = '0;
        wr_err_clr = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_reg_bank.md
Name: onehot_reg_bank

Overview:
- Register bank that consumes the one-hot write-enable vector produced by the `dmux1bit` demultiplexer, which is driven by the write-address select.
- Stores 2**NB_SEL words of BUS_WIDTH bits.
- Provides two combinational read ports, a per-register "written" mask and a sticky error flag for malformed (multi-hot) enables.
- Forms the storage stage directly downstream of the write-address demux in the CPU datapath.

Parameters:
- BUS_WIDTH, 8: data word width in bits.
- NB_SEL, 3: select width. Register count NB_REGS = 2**NB_SEL.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  2**NB_SEL  one-hot write enable from the `dmux1bit` output; bit i targets register i.
- wr_data  input  BUS_WIDTH  write data.
- rd_sel_a  input  NB_SEL  read port A register index.
- rd_sel_b  input  NB_SEL  read port B register index.
- rd_data_a  output  BUS_WIDTH  register contents at rd_sel_a.
- rd_data_b  output  BUS_WIDTH  register contents at rd_sel_b.
- rd_valid_a  output  1  high when register rd_sel_a has been written since reset.
- rd_valid_b  output  1  high when register rd_sel_b has been written since reset.
- written  output  2**NB_SEL  per-register written mask.
- wr_err  output  1  sticky flag: a multi-hot wr_en was presented.
- wr_err_clr  input  1  synchronous clear for wr_err.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all registers to 0, `written` to 0 and wr_err to 0.
  - Outputs reflect the cleared state immediately, without waiting for a clock edge.
  - Reset asserted mid-write discards that write.
- Write classification each rising edge, based on popcount(wr_en):
  - 0: no write, no error.
  - Exactly 1 (bit i): reg[i] <= wr_data and written[i] <= 1. Visible on the read ports from the cycle after the edge (1-cycle write latency).
  - 2 or more: the write is dropped entirely (no register and no `written` bit changes), and wr_err <= 1.
- wr_err update:
  - wr_err_clr high clears wr_err at the edge.
  - If a multi-hot error occurs in the same cycle as wr_err_clr, set wins and wr_err stays 1.
- Reads:
  - Purely combinational: rd_data_x = reg[rd_sel_x], rd_valid_x = written[rd_sel_x].
  - A read of an unwritten register returns 0 with rd_valid low.
  - Both ports may select the same register; each returns identical data.
- Rewrites:
  - Repeated writes to the same register overwrite it; the `written` bit remains 1.
- Wrap-around:
  - None. Every rd_sel value in 0..NB_REGS-1 is legal.
- X handling:
  - X or Z bits on wr_en are treated as a multi-hot error in simulation (no write, wr_err set). Synthesis does not need to model this.
- Implementation notes:
  - Popcount / one-hot check is combinational on wr_en.
  - Storage is flops, not an inferred RAM, so the asynchronous reset applies to every entry.

Optional Feature:
- Macro REG_BANK_BYPASS_EN.
- Defined: write-first forwarding.
  - If wr_en is exactly one-hot on bit i and rd_sel_x == i, rd_data_x = wr_data and rd_valid_x = 1 in the same cycle.
  - Forwarding is combinational, before the edge.
  - Multi-hot wr_en is never forwarded.
- Undefined: reads return the pre-edge stored value and valid bit; the new data appears the next cycle.
- Register state, `written` and wr_err behaviour are identical in both builds.

Test Plan:
- Reset sequence: hold reset_n=0, sweep rd_sel_a across 0..7 -> rd_data_a=0x00, rd_valid_a=0, written=8'h00, wr_err=0.
- Single write: wr_en=8'b0000_1000, wr_data=0xA5, one edge, then rd_sel_a=3 -> rd_data_a=0xA5, rd_valid_a=1, written=8'h08.
  - In the build without REG_BANK_BYPASS_EN, rd_data_a=0x00 in the cycle before that edge.
- Multi-hot rejection: wr_en=8'b0011_0000, wr_data=0xFF -> reg4 and reg5 unchanged (0x00), written unchanged, wr_err=1 after the edge.
  - Next cycle, apply wr_err_clr=1 together with wr_en=8'b1000_0001 -> wr_err remains 1.
  - Then wr_err_clr=1 with wr_en=0 -> wr_err=0.
- Dual read / overwrite: write 0x11 to reg2, then 0x22 to reg2, with rd_sel_a=rd_sel_b=2 -> both ports read 0x22, written[2]=1.
- Bypass (REG_BANK_BYPASS_EN defined): wr_en=8'b0100_0000, wr_data=0x5C, rd_sel_b=6 -> rd_data_b=0x5C and rd_valid_b=1 in the same cycle, before the edge.
- Async reset mid-operation: write 0x77 to reg7, then pulse reset_n low between clock edges -> rd_data for reg7=0x00, written=0 immediately.
  - A write presented in the edge following release takes effect normally.
